// File: rtl/wb_pkg.sv
// Shared types for the writeback stage buffer: data/address widths, the
// buffered entry layout and the FIFO index/occupancy types.
package wb_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

    typedef logic       idx_t;
    typedef logic [1:0] cnt_t;

endpackage

// File: rtl/wb_fifo2.sv
// Generic 2-entry pointer FIFO. Exposes the head (oldest) entry and the
// youngest entry (tail-1). The caller guarantees push only when not full and
// pop only when not empty.
module wb_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o,
    output logic [W-1:0] young_o
);
    import wb_pkg::*;

    logic [W-1:0] mem_q [2];
    idx_t         head_q, tail_q;
    cnt_t         count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= '0;
        end else if (flush_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= wdata_i;
                tail_q        <= ~tail_q;
            end
            if (pop_i) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];
    // With one pointer bit, tail-1 is simply the other slot.
    assign young_o = mem_q[~tail_q];

endmodule

// File: rtl/wb_stage_buf.sv
// Writeback-side stage buffer: captures MEM results (ALU or load data) into a
// 2-entry FIFO and drains them to the register-file write port.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_reg/fwd_data for EX bypass.
module wb_stage_buf
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_MEM,
    output logic              ready_MEM,
    input  logic              WRegEn_MEM,
    input  logic              MemToReg_MEM,
    input  logic [ADDR_W-1:0] WReg1_MEM,
    input  logic [DATA_W-1:0] alu_res_MEM,
    input  logic [DATA_W-1:0] mem_rdata_MEM,
    input  logic              flush,
    input  logic              rf_stall,
    output logic              WRegEn_WB,
    output logic [ADDR_W-1:0] WReg1_WB,
    output logic [DATA_W-1:0] WData_WB,
    output logic [1:0]        count
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // Handshake: a transfer happens on a rising edge where valid_MEM and
    // ready_MEM are both high and flush is low; ready_MEM depends only on the
    // registered occupancy, never on valid_MEM or on a same-cycle pop.
    wb_entry_t in_entry, head, young;
    cnt_t      cnt;
    logic      push, pop, not_empty;

    assign in_entry.wen   = WRegEn_MEM;
    assign in_entry.waddr = WReg1_MEM;
    assign in_entry.wdata = MemToReg_MEM ? mem_rdata_MEM : alu_res_MEM;

    assign not_empty = (cnt != 2'd0);
    assign ready_MEM = (cnt < 2'(DEPTH));
    assign push      = valid_MEM & ready_MEM & ~flush;
    assign pop       = not_empty & ~rf_stall & ~flush;

    wb_fifo2 #(.W($bits(wb_entry_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (in_entry),
        .count_o (cnt),
        .head_o  (head),
        .young_o (young)
    );

    assign count     = cnt;
    assign WRegEn_WB = pop & head.wen;
    assign WReg1_WB  = not_empty ? head.waddr : '0;
    assign WData_WB  = not_empty ? head.wdata : '0;

`ifdef WB_FWD_EN
    // Youngest writing entry wins; the head is only a candidate when it is
    // the older of two entries.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_reg   = '0;
        fwd_data  = '0;
        if (!flush) begin
            if (not_empty && young.wen) begin
                fwd_valid = 1'b1;
                fwd_reg   = young.waddr;
                fwd_data  = young.wdata;
            end else if (cnt == 2'd2 && head.wen) begin
                fwd_valid = 1'b1;
                fwd_reg   = head.waddr;
                fwd_data  = head.wdata;
            end
        end
    end
`else
    logic unused_young;
    assign unused_young = ^young;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed self-checking bench for wb_stage_buf; forwarding checks are built
// only when WB_FWD_EN is defined.
module tb_wb_stage_buf;
    import wb_pkg::*;

    logic              clk;
    logic              rst;
    logic              valid_MEM;
    logic              ready_MEM;
    logic              WRegEn_MEM;
    logic              MemToReg_MEM;
    logic [ADDR_W-1:0] WReg1_MEM;
    logic [DATA_W-1:0] alu_res_MEM;
    logic [DATA_W-1:0] mem_rdata_MEM;
    logic              flush;
    logic              rf_stall;
    logic              WRegEn_WB;
    logic [ADDR_W-1:0] WReg1_WB;
    logic [DATA_W-1:0] WData_WB;
    logic [1:0]        count;
`ifdef WB_FWD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_reg;
    logic [DATA_W-1:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage_buf dut (
        .clk           (clk),
        .rst           (rst),
        .valid_MEM     (valid_MEM),
        .ready_MEM     (ready_MEM),
        .WRegEn_MEM    (WRegEn_MEM),
        .MemToReg_MEM  (MemToReg_MEM),
        .WReg1_MEM     (WReg1_MEM),
        .alu_res_MEM   (alu_res_MEM),
        .mem_rdata_MEM (mem_rdata_MEM),
        .flush         (flush),
        .rf_stall      (rf_stall),
        .WRegEn_WB     (WRegEn_WB),
        .WReg1_WB      (WReg1_WB),
        .WData_WB      (WData_WB),
        .count         (count)
`ifdef WB_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data)
`endif
    );

    // Clock: rising edges at 5, 15, 25 ...; inputs change on the falling edge
    // and outputs are sampled 1 ns later.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic wen, input logic m2r,
                         input logic [ADDR_W-1:0] r,
                         input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] mrd);
        valid_MEM     = v;
        WRegEn_MEM    = wen;
        MemToReg_MEM  = m2r;
        WReg1_MEM     = r;
        alu_res_MEM   = alu;
        mem_rdata_MEM = mrd;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        rf_stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        step();
        #1;
        n_checks++; if (count !== 2'd0) begin $display("FAIL reset_count got %0d exp 0", count); n_fail++; end
        n_checks++; if (ready_MEM !== 1'b1) begin $display("FAIL reset_ready got %b exp 1", ready_MEM); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0) begin $display("FAIL reset_wen got %b exp 0", WRegEn_WB); n_fail++; end
        n_checks++; if (WReg1_WB !== 3'd0) begin $display("FAIL reset_waddr got %0d exp 0", WReg1_WB); n_fail++; end
        n_checks++; if (WData_WB !== 64'd0) begin $display("FAIL reset_wdata got %h exp 0", WData_WB); n_fail++; end
        step();
        rst = 1'b1;
    endtask

    task automatic test_single_alu();
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd3, 64'hAAAA, 64'h0);
        #1;
        n_checks++; if (WRegEn_WB !== 1'b0) begin $display("FAIL alu_no_passthru got %b exp 0", WRegEn_WB); n_fail++; end
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (count !== 2'd1) begin $display("FAIL alu_count got %0d exp 1", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b1) begin $display("FAIL alu_wen got %b exp 1", WRegEn_WB); n_fail++; end
        n_checks++; if (WReg1_WB !== 3'd3) begin $display("FAIL alu_waddr got %0d exp 3", WReg1_WB); n_fail++; end
        n_checks++; if (WData_WB !== 64'hAAAA) begin $display("FAIL alu_wdata got %h exp aaaa", WData_WB); n_fail++; end
        step();
        #1;
        n_checks++; if (count !== 2'd0) begin $display("FAIL alu_drained got %0d exp 0", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0) begin $display("FAIL alu_idle_wen got %b exp 0", WRegEn_WB); n_fail++; end
    endtask

    task automatic test_load_select();
        step();
        drive(1'b1, 1'b1, 1'b1, 3'd7, 64'hFFFF, 64'h1234);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (WData_WB !== 64'h1234) begin $display("FAIL load_wdata got %h exp 1234", WData_WB); n_fail++; end
        n_checks++; if (WReg1_WB !== 3'd7) begin $display("FAIL load_waddr got %0d exp 7", WReg1_WB); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b1) begin $display("FAIL load_wen got %b exp 1", WRegEn_WB); n_fail++; end
        step();
    endtask

    task automatic test_back_pressure();
        step();
        rf_stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd1, 64'h100, 64'd0);
        #1;
        n_checks++; if (ready_MEM !== 1'b1) begin $display("FAIL bp_ready0 got %b exp 1", ready_MEM); n_fail++; end
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h200, 64'd0);
        #1;
        n_checks++; if (count !== 2'd1) begin $display("FAIL bp_count1 got %0d exp 1", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0) begin $display("FAIL bp_stalled_wen got %b exp 0", WRegEn_WB); n_fail++; end
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd4, 64'h400, 64'd0);
        #1;
        n_checks++; if (count !== 2'd2) begin $display("FAIL bp_count2 got %0d exp 2", count); n_fail++; end
        n_checks++; if (ready_MEM !== 1'b0) begin $display("FAIL bp_full_ready got %b exp 0", ready_MEM); n_fail++; end
        step();
        #1;
        n_checks++; if (count !== 2'd2) begin $display("FAIL bp_held_count got %0d exp 2", count); n_fail++; end
        n_checks++; if (WReg1_WB !== 3'd1 || WData_WB !== 64'h100) begin
            $display("FAIL bp_head_stable got %0d/%h exp 1/100", WReg1_WB, WData_WB); n_fail++; end
        step();
        rf_stall = 1'b0;
        #1;
        n_checks++; if (ready_MEM !== 1'b0) begin $display("FAIL bp_pop_cycle_ready got %b exp 0", ready_MEM); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b1 || WReg1_WB !== 3'd1 || WData_WB !== 64'h100) begin
            $display("FAIL bp_drain0 got %b/%0d/%h exp 1/1/100", WRegEn_WB, WReg1_WB, WData_WB); n_fail++; end
        step();
        #1;
        n_checks++; if (count !== 2'd1 || ready_MEM !== 1'b1) begin
            $display("FAIL bp_after_pop got %0d/%b exp 1/1", count, ready_MEM); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b1 || WReg1_WB !== 3'd2 || WData_WB !== 64'h200) begin
            $display("FAIL bp_drain1 got %b/%0d/%h exp 1/2/200", WRegEn_WB, WReg1_WB, WData_WB); n_fail++; end
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (count !== 2'd1) begin $display("FAIL bp_third_accepted got %0d exp 1", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b1 || WReg1_WB !== 3'd4 || WData_WB !== 64'h400) begin
            $display("FAIL bp_drain2 got %b/%0d/%h exp 1/4/400", WRegEn_WB, WReg1_WB, WData_WB); n_fail++; end
        step();
        #1;
        n_checks++; if (count !== 2'd0) begin $display("FAIL bp_empty got %0d exp 0", count); n_fail++; end
    endtask

    task automatic test_store();
        step();
        drive(1'b1, 1'b0, 1'b0, 3'd6, 64'h55, 64'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (count !== 2'd1) begin $display("FAIL store_count got %0d exp 1", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0) begin $display("FAIL store_wen got %b exp 0", WRegEn_WB); n_fail++; end
        n_checks++; if (WReg1_WB !== 3'd6 || WData_WB !== 64'h55) begin
            $display("FAIL store_head got %0d/%h exp 6/55", WReg1_WB, WData_WB); n_fail++; end
        step();
        #1;
        n_checks++; if (count !== 2'd0 || WRegEn_WB !== 1'b0) begin
            $display("FAIL store_popped got %0d/%b exp 0/0", count, WRegEn_WB); n_fail++; end
    endtask

    task automatic test_flush();
        step();
        rf_stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd1, 64'h11, 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h22, 64'd0);
        step();
        rf_stall = 1'b0;
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd5, 64'h99, 64'd0);
        #1;
        n_checks++; if (count !== 2'd2) begin $display("FAIL flush_pre_count got %0d exp 2", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0) begin $display("FAIL flush_cycle_wen got %b exp 0", WRegEn_WB); n_fail++; end
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (count !== 2'd0) begin $display("FAIL flush_count got %0d exp 0", count); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0 || WReg1_WB !== 3'd0) begin
            $display("FAIL flush_outputs got %b/%0d exp 0/0", WRegEn_WB, WReg1_WB); n_fail++; end
        // Flush with room available: the concurrent push must still be dropped.
        step();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd3, 64'h77, 64'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (count !== 2'd0) begin $display("FAIL flush_drop_push got %0d exp 0", count); n_fail++; end
        step();
        #1;
        n_checks++; if (WRegEn_WB !== 1'b0 || WData_WB !== 64'd0) begin
            $display("FAIL flush_never_appears got %b/%h exp 0/0", WRegEn_WB, WData_WB); n_fail++; end
    endtask

    task automatic test_reset_mid_stall();
        step();
        rf_stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'd6, 64'd0, 64'hBEEF);
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd7, 64'hCAFE, 64'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (count !== 2'd2) begin $display("FAIL rst_pre_count got %0d exp 2", count); n_fail++; end
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 2'd0 || ready_MEM !== 1'b1) begin
            $display("FAIL rst_async_count got %0d/%b exp 0/1", count, ready_MEM); n_fail++; end
        n_checks++; if (WRegEn_WB !== 1'b0 || WReg1_WB !== 3'd0 || WData_WB !== 64'd0) begin
            $display("FAIL rst_async_outputs got %b/%0d/%h exp 0/0/0", WRegEn_WB, WReg1_WB, WData_WB); n_fail++; end
        step();
        rst = 1'b1;
        rf_stall = 1'b0;
        step();
        #1;
        n_checks++; if (count !== 2'd0 || WRegEn_WB !== 1'b0) begin
            $display("FAIL rst_no_write got %0d/%b exp 0/0", count, WRegEn_WB); n_fail++; end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] regs [4];
        logic [DATA_W-1:0] vals [4];
        regs[0] = 3'd1; vals[0] = 64'h0101_0101_0101_0101;
        regs[1] = 3'd2; vals[1] = 64'h0202;
        regs[2] = 3'd0; vals[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        regs[3] = 3'd5; vals[3] = 64'h5;
        rf_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) drive(1'b1, 1'b1, 1'b0, regs[i], vals[i], 64'd0);
            else       drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
            #1;
            if (i > 0) begin
                n_checks++;
                if (count !== 2'd1 || WRegEn_WB !== 1'b1 || WReg1_WB !== regs[i-1] || WData_WB !== vals[i-1]) begin
                    $display("FAIL b2b_%0d got %0d/%b/%0d/%h exp 1/1/%0d/%h", i, count, WRegEn_WB,
                             WReg1_WB, WData_WB, regs[i-1], vals[i-1]);
                    n_fail++;
                end
            end
        end
        step();
        #1;
        n_checks++; if (count !== 2'd0) begin $display("FAIL b2b_empty got %0d exp 0", count); n_fail++; end
    endtask

`ifdef WB_FWD_EN
    task automatic test_forward();
        step();
        rf_stall = 1'b1;
        #1;
        n_checks++; if (fwd_valid !== 1'b0) begin $display("FAIL fwd_empty got %b exp 0", fwd_valid); n_fail++; end
        drive(1'b1, 1'b1, 1'b0, 3'd5, 64'h11, 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 3'd5, 64'h22, 64'd0);
        #1;
        n_checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 3'd5 || fwd_data !== 64'h11) begin
            $display("FAIL fwd_one got %b/%0d/%h exp 1/5/11", fwd_valid, fwd_reg, fwd_data); n_fail++; end
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 3'd5 || fwd_data !== 64'h22) begin
            $display("FAIL fwd_youngest got %b/%0d/%h exp 1/5/22", fwd_valid, fwd_reg, fwd_data); n_fail++; end
        flush = 1'b1;
        #1;
        n_checks++; if (fwd_valid !== 1'b0) begin $display("FAIL fwd_flush got %b exp 0", fwd_valid); n_fail++; end
        step();
        flush = 1'b0;
        // Older entry writes, younger is a store: the older one is forwarded.
        drive(1'b1, 1'b1, 1'b0, 3'd4, 64'h44, 64'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'd6, 64'h66, 64'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #1;
        n_checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 3'd4 || fwd_data !== 64'h44) begin
            $display("FAIL fwd_older got %b/%0d/%h exp 1/4/44", fwd_valid, fwd_reg, fwd_data); n_fail++; end
        flush = 1'b1;
        step();
        flush = 1'b0;
        rf_stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_alu();
        test_load_select();
        test_back_pressure();
        test_store();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef WB_FWD_EN
        test_forward();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
